// File: rtl/adder_arbiter_if.sv
// Request/response bundle between the fixed-point clients and the shared adder.
// Operands are packed per requester: entry i occupies bits [i*WIDTH +: WIDTH].
interface adder_arbiter_if #(
    parameter int WIDTH   = 8,
    parameter int NUM_REQ = 4,
    parameter int ID_W    = $clog2(NUM_REQ)
);
    logic [NUM_REQ-1:0]            req_valid;
    logic [NUM_REQ-1:0]            req_ready;
    logic [NUM_REQ-1:0][WIDTH-1:0] req_operand_a;
    logic [NUM_REQ-1:0][WIDTH-1:0] req_operand_b;
    logic                          rsp_valid;
    logic                          rsp_ready;
    logic [ID_W-1:0]               rsp_id;
    logic [WIDTH-1:0]              rsp_result;
    logic                          rsp_overflow;
    logic                          busy;

    // Requester / downstream side
    modport master (
        output req_valid, req_operand_a, req_operand_b, rsp_ready,
        input  req_ready, rsp_valid, rsp_id, rsp_result, rsp_overflow, busy
    );

    // Arbiter side
    modport slave (
        input  req_valid, req_operand_a, req_operand_b, rsp_ready,
        output req_ready, rsp_valid, rsp_id, rsp_result, rsp_overflow, busy
    );
endinterface

// File: rtl/adder_arbiter.sv
// Round-robin arbiter in front of one shared signed fixed-point adder.
// One transaction in flight: IDLE (grant) -> EXEC (add) -> RESP (hold result).
module adder_arbiter #(
    parameter int WIDTH         = 8,
    parameter int INTEGERWIDTH  = 4,
    parameter int FRACTIONWIDTH = 4,
    parameter int NUM_REQ       = 4,
    parameter int SATURATE      = 1,
    parameter int ID_W          = $clog2(NUM_REQ)
) (
    input logic            clk,
    input logic            rst,
    adder_arbiter_if.slave bus
);
    if (INTEGERWIDTH + FRACTIONWIDTH != WIDTH) begin : g_bad_qfmt
        $error("adder_arbiter: INTEGERWIDTH + FRACTIONWIDTH must equal WIDTH");
    end
    if (NUM_REQ < 2) begin : g_bad_nreq
        $error("adder_arbiter: NUM_REQ must be at least 2");
    end

    typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

    localparam logic [WIDTH-1:0] POS_MAX = {1'b0, {(WIDTH-1){1'b1}}};
    localparam logic [WIDTH-1:0] NEG_MIN = {1'b1, {(WIDTH-1){1'b0}}};

    state_t           state_q, state_d;
    logic [ID_W-1:0]  rr_ptr, id_q, gnt_idx, idx;
    logic             gnt_found, take;
    int               s;
    logic [WIDTH-1:0] op_a, op_b, res;
    logic [WIDTH:0]   sum;
    logic             ovf;
    logic             rsp_valid_q, rsp_ovf_q;
    logic [ID_W-1:0]  rsp_id_q;
    logic [WIDTH-1:0] rsp_result_q;

    // First valid requester scanning upward from rr_ptr, wrapping at NUM_REQ
    always_comb begin
        gnt_found = 1'b0;
        gnt_idx   = '0;
        s         = 0;
        idx       = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            s = int'(rr_ptr) + k;
            if (s >= NUM_REQ) s = s - NUM_REQ;
            idx = ID_W'(s);
            if (!gnt_found && bus.req_valid[idx]) begin
                gnt_found = 1'b1;
                gnt_idx   = idx;
            end
        end
    end

    // Ready is withheld during reset so a requester never sees an ignored handshake
    assign take = gnt_found && (state_q == IDLE) && !rst;

    // One-hot ready to the granted requester only
    always_comb begin
        bus.req_ready = '0;
        if (take) bus.req_ready[gnt_idx] = 1'b1;
    end

    // Sign-extended add with overflow detection and optional clamping
    always_comb begin
        sum = {op_a[WIDTH-1], op_a} + {op_b[WIDTH-1], op_b};
        ovf = (op_a[WIDTH-1] == op_b[WIDTH-1]) && (sum[WIDTH-1] != op_a[WIDTH-1]);
        res = sum[WIDTH-1:0];
        if (SATURATE != 0 && ovf) res = op_a[WIDTH-1] ? NEG_MIN : POS_MAX;
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (take) state_d = EXEC;
            EXEC:    state_d = RESP;
            RESP:    if (bus.rsp_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // State register
    always_ff @(posedge clk) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    // Operand capture, round-robin pointer and response registers
    always_ff @(posedge clk) begin
        if (rst) begin
            rr_ptr       <= '0;
            id_q         <= '0;
            op_a         <= '0;
            op_b         <= '0;
            rsp_valid_q  <= 1'b0;
            rsp_id_q     <= '0;
            rsp_result_q <= '0;
            rsp_ovf_q    <= 1'b0;
        end else begin
            case (state_q)
                IDLE: if (take) begin
                    op_a   <= bus.req_operand_a[gnt_idx];
                    op_b   <= bus.req_operand_b[gnt_idx];
                    id_q   <= gnt_idx;
                    rr_ptr <= (gnt_idx == ID_W'(NUM_REQ - 1)) ? '0 : gnt_idx + 1'b1;
                end
                EXEC: begin
                    rsp_valid_q  <= 1'b1;
                    rsp_id_q     <= id_q;
                    rsp_result_q <= res;
                    rsp_ovf_q    <= ovf;
                end
                RESP: if (bus.rsp_ready) rsp_valid_q <= 1'b0;
                default: ;
            endcase
        end
    end

    assign bus.rsp_valid    = rsp_valid_q;
    assign bus.rsp_id       = rsp_id_q;
    assign bus.rsp_result   = rsp_result_q;
    assign bus.rsp_overflow = rsp_ovf_q;
    assign bus.busy         = (state_q != IDLE);
endmodule

// File: tb/tb_adder_arbiter.sv
// Bench for adder_arbiter: a saturating and a wrapping instance run in lockstep
// on identical stimulus; a monitor pops expected responses from a shared queue.
module tb_adder_arbiter;
    localparam int W  = 8;
    localparam int N  = 4;
    localparam int IW = 2;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    adder_arbiter_if #(.WIDTH(W), .NUM_REQ(N), .ID_W(IW)) ifs ();
    adder_arbiter_if #(.WIDTH(W), .NUM_REQ(N), .ID_W(IW)) ifw ();

    assign ifw.req_valid     = ifs.req_valid;
    assign ifw.req_operand_a = ifs.req_operand_a;
    assign ifw.req_operand_b = ifs.req_operand_b;
    assign ifw.rsp_ready     = ifs.rsp_ready;

    adder_arbiter #(.WIDTH(W), .INTEGERWIDTH(4), .FRACTIONWIDTH(4), .NUM_REQ(N),
                    .SATURATE(1), .ID_W(IW)) u_sat (.clk(clk), .rst(rst), .bus(ifs));
    adder_arbiter #(.WIDTH(W), .INTEGERWIDTH(4), .FRACTIONWIDTH(4), .NUM_REQ(N),
                    .SATURATE(0), .ID_W(IW)) u_wrap (.clk(clk), .rst(rst), .bus(ifw));

    typedef struct packed {
        logic [1:0] id;
        logic [7:0] res_s;
        logic [7:0] res_w;
        logic       ovf;
    } exp_t;

    exp_t exp_q[$];
    exp_t e;
    int   total = 0;
    int   bad   = 0;
    int   ord[5] = '{0, 1, 2, 3, 0};

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s actual=0x%0h required=0x%0h", name, act, req);
        end
    endtask

    // Scoreboard monitor: compare both instances on every response handshake
    always @(negedge clk) begin
        if (!rst && ifs.rsp_valid) begin
            if (exp_q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_rsp actual id=%0d required=no response", ifs.rsp_id);
            end else if (ifs.rsp_ready) begin
                e = exp_q.pop_front();
                chk("rsp_id",       32'(ifs.rsp_id),       32'(e.id));
                chk("rsp_res_sat",  32'(ifs.rsp_result),   32'(e.res_s));
                chk("rsp_ovf_sat",  32'(ifs.rsp_overflow), 32'(e.ovf));
                chk("rsp_valid_wr", 32'(ifw.rsp_valid),    1);
                chk("rsp_id_wr",    32'(ifw.rsp_id),       32'(e.id));
                chk("rsp_res_wrap", 32'(ifw.rsp_result),   32'(e.res_w));
                chk("rsp_ovf_wrap", 32'(ifw.rsp_overflow), 32'(e.ovf));
            end
        end
    end

    task automatic issue(input logic [1:0] id, input logic [7:0] a, input logic [7:0] b,
                         input logic [7:0] rs, input logic [7:0] rw, input logic ov);
        int n;
        @(posedge clk); #1;
        ifs.req_operand_a[id] = a;
        ifs.req_operand_b[id] = b;
        ifs.req_valid[id]     = 1'b1;
        n = 0;
        do begin @(negedge clk); n++; end while (!ifs.req_ready[id] && n < 20);
        chk("grant", 32'(ifs.req_ready), 32'(1) << id);
        exp_q.push_back('{id: id, res_s: rs, res_w: rw, ovf: ov});
        @(posedge clk); #1;
        ifs.req_valid[id] = 1'b0;
        @(negedge clk);
        chk("exec_busy",  32'(ifs.busy),      1);
        chk("exec_valid", 32'(ifs.rsp_valid), 0);
        chk("exec_ready", 32'(ifs.req_ready), 0);
        @(negedge clk);
        chk("latency_valid", 32'(ifs.rsp_valid), 1);
        chk("resp_busy",     32'(ifs.busy),      1);
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < 30) begin @(negedge clk); n++; end
        chk("drain", 32'(exp_q.size()), 0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [3:0] gv[5];
        int         gc[5];
        int         cnt, n;
        logic [7:0] r_hold;
        logic [1:0] id_hold;
        logic       ov_hold;

        ifs.req_valid     = '0;
        ifs.req_operand_a = '0;
        ifs.req_operand_b = '0;
        ifs.rsp_ready     = 1'b1;

        // Reset values
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_valid",  32'(ifs.rsp_valid),    0);
        chk("rst_busy",   32'(ifs.busy),         0);
        chk("rst_ready",  32'(ifs.req_ready),    0);
        chk("rst_result", 32'(ifs.rsp_result),   0);
        chk("rst_ovf",    32'(ifs.rsp_overflow), 0);
        chk("rst_id",     32'(ifs.rsp_id),       0);
        @(posedge clk); #1 rst = 1'b0;

        // Directed arithmetic vectors: id, A, B, saturated, wrapped, overflow
        issue(2'd0, 8'h18, 8'h28, 8'h40, 8'h40, 1'b0);
        issue(2'd1, 8'h70, 8'h20, 8'h7F, 8'h90, 1'b1);
        issue(2'd2, 8'h80, 8'hF0, 8'h80, 8'h70, 1'b1);
        issue(2'd3, 8'h10, 8'hF0, 8'h00, 8'h00, 1'b0);
        issue(2'd0, 8'h7F, 8'h01, 8'h7F, 8'h80, 1'b1);
        issue(2'd1, 8'h80, 8'h80, 8'h80, 8'h00, 1'b1);
        issue(2'd2, 8'hC0, 8'hC0, 8'h80, 8'h80, 1'b0);
        issue(2'd3, 8'h7F, 8'h80, 8'hFF, 8'hFF, 1'b0);
        drain();

        // Round robin with all requesters valid: 0,1,2,3,0 spaced 3 cycles
        for (int i = 0; i < 5; i++)
            exp_q.push_back('{id: 2'(ord[i]), res_s: 8'(8'h11 + ord[i]),
                              res_w: 8'(8'h11 + ord[i]), ovf: 1'b0});
        @(posedge clk); #1;
        for (int i = 0; i < N; i++) begin
            ifs.req_operand_a[i] = 8'(i + 1);
            ifs.req_operand_b[i] = 8'h10;
        end
        ifs.req_valid = '1;
        cnt = 0;
        n = 0;
        while (cnt < 5 && n < 40) begin
            @(negedge clk);
            n++;
            if (ifs.req_ready != 0) begin
                gv[cnt] = ifs.req_ready;
                gc[cnt] = n;
                cnt++;
            end
        end
        @(posedge clk); #1 ifs.req_valid = '0;
        chk("rr_count", 32'(cnt), 5);
        for (int k = 0; k < 5; k++) chk("rr_order", 32'(gv[k]), 32'(1) << ord[k]);
        for (int k = 1; k < 5; k++) chk("rr_gap", 32'(gc[k] - gc[k-1]), 3);
        drain();

        // Back-pressure: response held 5 cycles, requester 2 waiting meanwhile
        @(posedge clk); #1 ifs.rsp_ready = 1'b0;
        issue(2'd1, 8'h25, 8'h13, 8'h38, 8'h38, 1'b0);
        r_hold  = ifs.rsp_result;
        id_hold = ifs.rsp_id;
        ov_hold = ifs.rsp_overflow;
        for (int k = 0; k < 4; k++) begin
            @(posedge clk); #1;
            if (k == 0) begin
                ifs.req_operand_a[2] = 8'h01;
                ifs.req_operand_b[2] = 8'h02;
                ifs.req_valid[2]     = 1'b1;
            end
            @(negedge clk);
            chk("bp_result", 32'(ifs.rsp_result),   32'(r_hold));
            chk("bp_id",     32'(ifs.rsp_id),       32'(id_hold));
            chk("bp_ovf",    32'(ifs.rsp_overflow), 32'(ov_hold));
            chk("bp_valid",  32'(ifs.rsp_valid),    1);
            chk("bp_ready",  32'(ifs.req_ready),    0);
        end
        @(posedge clk); #1 ifs.rsp_ready = 1'b1;
        @(negedge clk);
        chk("bp_release_ready", 32'(ifs.req_ready), 0);
        @(negedge clk);
        chk("bp_next_grant", 32'(ifs.req_ready), 32'h4);
        exp_q.push_back('{id: 2'd2, res_s: 8'h03, res_w: 8'h03, ovf: 1'b0});
        @(posedge clk); #1 ifs.req_valid[2] = 1'b0;
        drain();

        // Reset during EXEC drops the transaction and clears rr_ptr
        @(posedge clk); #1;
        ifs.req_operand_a[2] = 8'h11;
        ifs.req_operand_b[2] = 8'h22;
        ifs.req_valid[2]     = 1'b1;
        n = 0;
        do begin @(negedge clk); n++; end while (ifs.req_ready == 0 && n < 20);
        chk("pre_rst_grant", 32'(ifs.req_ready), 32'h4);
        @(posedge clk); #1;
        ifs.req_valid[2] = 1'b0;
        rst = 1'b1;
        @(negedge clk);
        chk("mid_exec_busy", 32'(ifs.busy), 1);
        @(posedge clk); #1 rst = 1'b0;
        @(negedge clk);
        chk("post_rst_valid",  32'(ifs.rsp_valid),    0);
        chk("post_rst_busy",   32'(ifs.busy),         0);
        chk("post_rst_ready",  32'(ifs.req_ready),    0);
        chk("post_rst_result", 32'(ifs.rsp_result),   0);
        chk("post_rst_ovf",    32'(ifs.rsp_overflow), 0);
        chk("post_rst_id",     32'(ifs.rsp_id),       0);
        @(posedge clk); #1;
        ifs.req_operand_a[2] = 8'h05;
        ifs.req_operand_b[2] = 8'h06;
        ifs.req_operand_a[3] = 8'h01;
        ifs.req_operand_b[3] = 8'h01;
        ifs.req_valid        = 4'b1100;
        @(negedge clk);
        chk("post_rst_grant", 32'(ifs.req_ready), 32'h4);
        exp_q.push_back('{id: 2'd2, res_s: 8'h0B, res_w: 8'h0B, ovf: 1'b0});
        @(posedge clk); #1 ifs.req_valid = '0;
        drain();
        repeat (3) @(negedge clk);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
